// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: forward-select codes, shadow record, match helpers.
package pipe_hazard_unit_pkg;

    localparam int unsigned REC_AW = 8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REC_AW-1:0] dst;
        logic              reg_write;
        logic              mem_read;
        logic              multi;
        logic [REC_AW-1:0] rs;
        logic [REC_AW-1:0] rt;
        logic              uses_rs;
        logic              uses_rt;
    } shadow_rec_t;

    localparam shadow_rec_t BUBBLE_REC = '0;

    // Register $0 is hard-wired and never produces a dependency.
    function automatic logic dst_hit(input shadow_rec_t rec, input logic [REC_AW-1:0] addr);
        return (rec.dst != '0) && (rec.dst == addr);
    endfunction

    function automatic logic writes_to(input shadow_rec_t rec, input logic [REC_AW-1:0] addr);
        return rec.valid && rec.reg_write && dst_hit(rec, addr);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_select.sv
// Picks the EX operand source for one register read; the nearer MEM producer wins over WB.
module fwd_select
    import pipe_hazard_unit_pkg::*;
#(
    parameter int unsigned FWD_EN = 1
) (
    input  shadow_rec_t       mem_rec,
    input  shadow_rec_t       wb_rec,
    input  logic [REC_AW-1:0] src,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (FWD_EN != 0) begin
            if (writes_to(mem_rec, src)) begin
                sel = FWD_MEM;
            end else if (writes_to(wb_rec, src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard unit: shadows EX/MEM/WB control, drives forwarding selects, stalls, flushes and multi-cycle holds.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned FWD_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst_addr,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_multi,
    input  logic              ex_branch_taken,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              ex_hold
);

    localparam int unsigned CNT_W = 4;

    shadow_rec_t       ex_q, mem_q, wb_q;
    shadow_rec_t       id_rec, ex_d, mem_d, wb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REC_AW-1:0] id_rs, id_rt;
    logic              hold, branch, load_use, raw_stall;
    logic              unused_rec_bits;

    // Unread sources collapse to $0 so they can never match a producer.
    assign id_rs = (id_valid && id_uses_rs) ? REC_AW'(id_rs_addr) : '0;
    assign id_rt = (id_valid && id_uses_rt) ? REC_AW'(id_rt_addr) : '0;

    always_comb begin
        id_rec = BUBBLE_REC;
        if (id_valid) begin
            id_rec.valid     = 1'b1;
            id_rec.dst       = REC_AW'(id_dst_addr);
            id_rec.reg_write = id_reg_write;
            id_rec.mem_read  = id_mem_read;
            id_rec.multi     = id_multi;
            id_rec.rs        = id_rs;
            id_rec.rt        = id_rt;
            id_rec.uses_rs   = id_uses_rs;
            id_rec.uses_rt   = id_uses_rt;
        end
    end

    assign hold      = (cnt_q != '0);
    assign branch    = ex_branch_taken && !hold;
    assign load_use  = (FWD_EN != 0) && ex_q.valid && ex_q.mem_read
                       && (dst_hit(ex_q, id_rs) || dst_hit(ex_q, id_rt));
    assign raw_stall = (FWD_EN == 0)
                       && (writes_to(ex_q, id_rs)  || writes_to(ex_q, id_rt)
                        || writes_to(mem_q, id_rs) || writes_to(mem_q, id_rt)
                        || writes_to(wb_q, id_rs)  || writes_to(wb_q, id_rt));

    // Priority: multi-cycle hold, then taken branch, then data stall.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        ex_hold      = 1'b0;
        if (hold) begin
            ex_hold     = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (branch) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use || raw_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Shadow pipeline advance; a held EX record feeds bubbles into MEM.
    always_comb begin
        ex_d  = ex_q;
        mem_d = ex_q;
        wb_d  = mem_q;
        cnt_d = cnt_q;
        if (hold) begin
            mem_d = BUBBLE_REC;
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            ex_d = id_ex_bubble ? BUBBLE_REC : id_rec;
            if (!id_ex_bubble && id_rec.valid && id_rec.multi) begin
                cnt_d = CNT_W'(MUL_LAT - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= BUBBLE_REC;
            mem_q <= BUBBLE_REC;
            wb_q  <= BUBBLE_REC;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    fwd_select #(.FWD_EN(FWD_EN)) u_fwd_a (
        .mem_rec (mem_q),
        .wb_rec  (wb_q),
        .src     (ex_q.rs),
        .sel     (forward_a)
    );

    fwd_select #(.FWD_EN(FWD_EN)) u_fwd_b (
        .mem_rec (mem_q),
        .wb_rec  (wb_q),
        .src     (ex_q.rt),
        .sel     (forward_b)
    );

    // Records carry full instruction context; not every field feeds a decision.
    assign unused_rec_bits = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: forwarding-mode and stall-mode instances share one stimulus.
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs_addr, id_rt_addr, id_dst_addr;
    logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_multi;
    logic       ex_branch_taken;

    logic [1:0] f1_fa, f1_fb, f0_fa, f0_fb;
    logic       f1_pc, f1_ifid, f1_bub, f1_flush, f1_hold;
    logic       f0_pc, f0_ifid, f0_bub, f0_flush, f0_hold;
    logic [4:0] ctrl1, ctrl0;

    int checks   = 0;
    int failures = 0;

    // ctrl = {pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_hold}
    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00100;
    localparam logic [4:0] C_HOLD  = 5'b00001;
    localparam logic [4:0] C_BR    = 5'b11110;

    assign ctrl1 = {f1_pc, f1_ifid, f1_bub, f1_flush, f1_hold};
    assign ctrl0 = {f0_pc, f0_ifid, f0_bub, f0_flush, f0_hold};

    always #5 clk = ~clk;

    pipe_hazard_unit #(.REG_AW(5), .MUL_LAT(4), .FWD_EN(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_multi(id_multi),
        .ex_branch_taken(ex_branch_taken),
        .forward_a(f1_fa), .forward_b(f1_fb),
        .pc_write(f1_pc), .if_id_write(f1_ifid), .id_ex_bubble(f1_bub),
        .if_id_flush(f1_flush), .ex_hold(f1_hold)
    );

    pipe_hazard_unit #(.REG_AW(5), .MUL_LAT(4), .FWD_EN(0)) dut_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_multi(id_multi),
        .ex_branch_taken(ex_branch_taken),
        .forward_a(f0_fa), .forward_b(f0_fb),
        .pc_write(f0_pc), .if_id_write(f0_ifid), .id_ex_bubble(f0_bub),
        .if_id_flush(f0_flush), .ex_hold(f0_hold)
    );

    task automatic drive_id(input logic v, input int rs, input int rt, input logic urs,
                            input logic urt, input int dst, input logic rw, input logic mr,
                            input logic mu);
        id_valid     = v;
        id_rs_addr   = 5'(rs);
        id_rt_addr   = 5'(rt);
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_dst_addr  = 5'(dst);
        id_reg_write = rw;
        id_mem_read  = mr;
        id_multi     = mu;
    endtask

    task automatic idle();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        idle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (ctrl1 !== C_RUN) begin failures++; $display("FAIL reset_ctrl: got %b expected %b", ctrl1, C_RUN); end
        checks++;
        if ({f1_fa, f1_fb} !== 4'b0000) begin failures++; $display("FAIL reset_fwd: got %b expected 0000", {f1_fa, f1_fb}); end
        checks++;
        if (ctrl0 !== C_RUN) begin failures++; $display("FAIL reset_ctrl_nofwd: got %b expected %b", ctrl0, C_RUN); end
    endtask

    task automatic test_forward_mem();
        do_reset();
        next_cycle(); drive_id(1, 1, 2, 1, 1, 3, 1, 0, 0);      // add $3,$1,$2
        next_cycle(); drive_id(1, 3, 7, 1, 1, 6, 1, 0, 0);      // sub $6,$3,$7
        #1;
        checks++;
        if (ctrl1 !== C_RUN) begin failures++; $display("FAIL fwd_mem_nostall: got %b expected %b", ctrl1, C_RUN); end
        next_cycle(); idle(); #1;
        checks++;
        if ({f1_fa, f1_fb} !== 4'b1000) begin failures++; $display("FAIL fwd_mem_sel: got %b expected 1000", {f1_fa, f1_fb}); end
    endtask

    task automatic test_forward_wb();
        do_reset();
        next_cycle(); drive_id(1, 1, 2, 1, 1, 3, 1, 0, 0);      // add $3
        next_cycle(); drive_id(1, 9, 10, 1, 1, 8, 1, 0, 0);     // or  $8
        next_cycle(); drive_id(1, 3, 3, 1, 1, 6, 1, 0, 0);      // sub $6,$3,$3
        next_cycle(); idle(); #1;
        checks++;
        if ({f1_fa, f1_fb} !== 4'b0101) begin failures++; $display("FAIL fwd_wb_sel: got %b expected 0101", {f1_fa, f1_fb}); end
        // Two back-to-back producers of $3: the younger (MEM) wins.
        do_reset();
        next_cycle(); drive_id(1, 1, 2, 1, 1, 3, 1, 0, 0);
        next_cycle(); drive_id(1, 4, 5, 1, 1, 3, 1, 0, 0);
        next_cycle(); drive_id(1, 7, 3, 1, 1, 6, 1, 0, 0);      // reads $3 on rt only
        next_cycle(); idle(); #1;
        checks++;
        if ({f1_fa, f1_fb} !== 4'b0010) begin failures++; $display("FAIL fwd_mem_priority: got %b expected 0010", {f1_fa, f1_fb}); end
    endtask

    task automatic test_load_use();
        do_reset();
        next_cycle(); drive_id(1, 1, 0, 1, 0, 4, 1, 1, 0);      // lw  $4
        next_cycle(); drive_id(1, 4, 2, 1, 1, 5, 1, 0, 0);      // add $5,$4,$2
        #1;
        checks++;
        if (ctrl1 !== C_STALL) begin failures++; $display("FAIL load_use_stall: got %b expected %b", ctrl1, C_STALL); end
        next_cycle(); drive_id(1, 4, 2, 1, 1, 5, 1, 0, 0);
        #1;
        checks++;
        if (ctrl1 !== C_RUN) begin failures++; $display("FAIL load_use_release: got %b expected %b", ctrl1, C_RUN); end
        next_cycle(); idle(); #1;
        checks++;
        if (f1_fa !== 2'b01) begin failures++; $display("FAIL load_use_fwd: got %b expected 01", f1_fa); end
    endtask

    task automatic test_multi();
        do_reset();
        next_cycle(); drive_id(1, 1, 2, 1, 1, 7, 1, 0, 1);      // mul $7
        for (int k = 0; k < 3; k++) begin
            next_cycle(); drive_id(1, 7, 9, 1, 1, 8, 1, 0, 0);  // add $8,$7,$9
            #1;
            checks++;
            if (ctrl1 !== C_HOLD) begin failures++; $display("FAIL multi_hold[%0d]: got %b expected %b", k, ctrl1, C_HOLD); end
        end
        next_cycle(); drive_id(1, 7, 9, 1, 1, 8, 1, 0, 0);
        #1;
        checks++;
        if (ctrl1 !== C_RUN) begin failures++; $display("FAIL multi_release: got %b expected %b", ctrl1, C_RUN); end
        next_cycle(); idle(); #1;
        checks++;
        if (f1_fa !== 2'b10) begin failures++; $display("FAIL multi_fwd: got %b expected 10", f1_fa); end
    endtask

    task automatic test_hold_load_use();
        do_reset();
        next_cycle(); drive_id(1, 1, 0, 1, 0, 4, 1, 1, 1);      // multi-cycle load into $4
        for (int k = 0; k < 3; k++) begin
            next_cycle(); drive_id(1, 4, 2, 1, 1, 5, 1, 0, 0);
            #1;
            checks++;
            if (ctrl1 !== C_HOLD) begin failures++; $display("FAIL hold_dominates[%0d]: got %b expected %b", k, ctrl1, C_HOLD); end
        end
        next_cycle(); drive_id(1, 4, 2, 1, 1, 5, 1, 0, 0);
        #1;
        checks++;
        if (ctrl1 !== C_STALL) begin failures++; $display("FAIL hold_then_load_use: got %b expected %b", ctrl1, C_STALL); end
        next_cycle(); drive_id(1, 4, 2, 1, 1, 5, 1, 0, 0);
        #1;
        checks++;
        if (ctrl1 !== C_RUN) begin failures++; $display("FAIL hold_load_use_release: got %b expected %b", ctrl1, C_RUN); end
    endtask

    task automatic test_branch();
        do_reset();
        next_cycle(); drive_id(1, 1, 0, 1, 0, 4, 1, 1, 0);      // lw $4
        next_cycle(); drive_id(1, 4, 2, 1, 1, 5, 1, 0, 0);
        ex_branch_taken = 1'b1;
        #1;
        checks++;
        if (ctrl1 !== C_BR) begin failures++; $display("FAIL branch_over_load_use: got %b expected %b", ctrl1, C_BR); end
        next_cycle(); ex_branch_taken = 1'b0; idle(); #1;
        checks++;
        if (ctrl1 !== C_RUN) begin failures++; $display("FAIL branch_after: got %b expected %b", ctrl1, C_RUN); end
        do_reset();
        next_cycle(); drive_id(1, 1, 2, 1, 1, 7, 1, 0, 1);      // mul
        next_cycle(); idle(); ex_branch_taken = 1'b1; #1;
        checks++;
        if (ctrl1 !== C_HOLD) begin failures++; $display("FAIL branch_ignored_in_hold: got %b expected %b", ctrl1, C_HOLD); end
        ex_branch_taken = 1'b0;
    endtask

    task automatic test_no_fwd();
        do_reset();
        next_cycle(); drive_id(1, 1, 2, 1, 1, 5, 1, 0, 0);      // add $5
        for (int k = 0; k < 3; k++) begin
            next_cycle(); drive_id(1, 5, 6, 1, 1, 9, 1, 0, 0);
            #1;
            checks++;
            if (ctrl0 !== C_STALL) begin failures++; $display("FAIL nofwd_stall[%0d]: got %b expected %b", k, ctrl0, C_STALL); end
            checks++;
            if ({f0_fa, f0_fb} !== 4'b0000) begin failures++; $display("FAIL nofwd_sel[%0d]: got %b expected 0000", k, {f0_fa, f0_fb}); end
        end
        next_cycle(); drive_id(1, 5, 6, 1, 1, 9, 1, 0, 0);
        #1;
        checks++;
        if (ctrl0 !== C_RUN) begin failures++; $display("FAIL nofwd_release: got %b expected %b", ctrl0, C_RUN); end
        next_cycle(); idle(); #1;
        checks++;
        if ({f0_fa, f0_fb} !== 4'b0000) begin failures++; $display("FAIL nofwd_sel_ex: got %b expected 0000", {f0_fa, f0_fb}); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        next_cycle(); drive_id(1, 1, 0, 1, 0, 0, 1, 1, 0);      // lw $0
        next_cycle(); drive_id(1, 0, 0, 1, 1, 9, 1, 0, 0);      // add $9,$0,$0
        #1;
        checks++;
        if (ctrl1 !== C_RUN) begin failures++; $display("FAIL zero_no_load_use: got %b expected %b", ctrl1, C_RUN); end
        checks++;
        if (ctrl0 !== C_RUN) begin failures++; $display("FAIL zero_no_raw: got %b expected %b", ctrl0, C_RUN); end
        next_cycle(); idle(); #1;
        checks++;
        if ({f1_fa, f1_fb} !== 4'b0000) begin failures++; $display("FAIL zero_no_fwd: got %b expected 0000", {f1_fa, f1_fb}); end
    endtask

    task automatic test_invalid_id();
        do_reset();
        next_cycle(); drive_id(0, 1, 0, 1, 0, 4, 1, 1, 0);      // lw fields but not valid
        #1;
        checks++;
        if (ctrl1 !== C_RUN) begin failures++; $display("FAIL invalid_id_ctrl: got %b expected %b", ctrl1, C_RUN); end
        next_cycle(); drive_id(1, 4, 2, 1, 1, 5, 1, 0, 0);
        #1;
        checks++;
        if (ctrl1 !== C_RUN) begin failures++; $display("FAIL invalid_no_load_use: got %b expected %b", ctrl1, C_RUN); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        next_cycle(); drive_id(1, 1, 2, 1, 1, 7, 1, 0, 1);      // mul
        next_cycle(); idle(); #1;
        checks++;
        if (ctrl1 !== C_HOLD) begin failures++; $display("FAIL mid_hold_active: got %b expected %b", ctrl1, C_HOLD); end
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0; #1;
        checks++;
        if (ctrl1 !== C_RUN) begin failures++; $display("FAIL mid_hold_aborted: got %b expected %b", ctrl1, C_RUN); end
        next_cycle(); #1;
        checks++;
        if (ctrl1 !== C_RUN) begin failures++; $display("FAIL mid_hold_stays_clear: got %b expected %b", ctrl1, C_RUN); end
    endtask

    initial begin
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        idle();
        test_reset();
        test_forward_mem();
        test_forward_wb();
        test_load_use();
        test_multi();
        test_hold_load_use();
        test_branch();
        test_no_fwd();
        test_zero_reg();
        test_invalid_id();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter MUL_LAT, default 4, EX occupancy in cycles of a multi-cycle op; legal range 2..15.
REQ-003 Parameter FWD_EN, default 1: 1 = forwarding mode; 0 = stall-until-writeback mode.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 Port list (name, direction, width, meaning):
  clk  in  1  clock.
  rst  in  1  synchronous active-high reset.
  id_valid  in  1  IF/ID holds a real instruction.
  id_rs_addr / id_rt_addr  in  REG_AW  source addresses in ID.
  id_uses_rs / id_uses_rt  in  1  source actually read.
  id_dst_addr  in  REG_AW  destination, already RegDst-resolved.
  id_reg_write / id_mem_read / id_multi  in  1  ID control bits.
  ex_branch_taken  in  1  branch resolved taken in EX.
  forward_a / forward_b  out  2  EX operand select: 00 RF/ID_EX, 01 WB data, 10 EX/MEM ALU result.
  pc_write / if_id_write  out  1  PC and IF/ID enables.
  id_ex_bubble  out  1  load a NOP into ID/EX.
  if_id_flush  out  1  clear IF/ID.
  ex_hold  out  1  hold ID/EX contents; bubble into EX/MEM.

Function
REQ-006 Block SHALL keep shadow records (valid, dst, reg_write, mem_read, multi, rs, rt, uses) for EX, MEM and WB, advanced each cycle along the datapath pipeline.
REQ-007 Address 0 SHALL never match for forwarding or hazard purposes.
REQ-008 FWD_EN=1: forward_x = 10 when MEM record valid, reg_write, dst == EX source; else 01 when the WB record matches likewise; else 00. MEM takes priority.
REQ-009 FWD_EN=0: forward_a/b SHALL be 00; any used ID source matching the dst of a valid reg_write record in EX, MEM or WB SHALL stall.
REQ-010 Load-use (FWD_EN=1): EX record mem_read && used ID source == EX dst SHALL stall one cycle.
REQ-011 Stall: pc_write=0, if_id_write=0, id_ex_bubble=1; combinational, same cycle.
REQ-012 Multi-cycle: on entry of a multi record into EX, a 4-bit counter SHALL load MUL_LAT-1. While the counter is nonzero, ex_hold=1, pc_write=0, if_id_write=0, and the MEM record receives a bubble. The counter decrements each cycle. At 0 the op advances.
REQ-013 ex_branch_taken SHALL be honoured only when ex_hold=0; it is ignored while the counter is nonzero.
REQ-014 Taken branch: if_id_flush=1, id_ex_bubble=1, pc_write=1. The branch SHALL override any simultaneous load-use or RAW stall.
REQ-015 Simultaneous load-use and multi hold: the hold SHALL dominate. The load-use check SHALL be re-evaluated after release.
REQ-016 id_valid=0 SHALL produce no hazard.
REQ-017 A bubbled record SHALL have valid=0.
REQ-018 Latency: all outputs SHALL be combinational from the current inputs and shadow state; shadow updates on the clk edge.

Reset
REQ-019 In the rst cycle all shadow records SHALL be invalid and the counter 0.
REQ-020 Outputs after reset: forward 00, pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, ex_hold=0.
REQ-021 rst during a multi hold SHALL abort the op, clearing the counter.

Structure
REQ-022 Shared package SHALL hold the forward-select encodings (FWD_RF, FWD_WB, FWD_MEM) and the shadow-record struct type.
REQ-023 One sub-module, fwd_select, SHALL compute a single 2-bit select and be instantiated for each of a and b.

Verification
REQ-024 FWD_EN=1: add $3 followed by sub using $3 -> forward_a=10 in the sub's EX cycle; with one instruction between them -> 01.
REQ-025 lw $4 followed by add reading $4 -> one cycle of pc_write=0 and id_ex_bubble=1, then forward_a=01.
REQ-026 MUL_LAT=4, multi op into EX -> ex_hold=1 for exactly 3 cycles; the next instruction's pc_write is held over the same 3 cycles.
REQ-027 Taken branch in the same cycle as a load-use condition -> if_id_flush=1, pc_write=1, no stall cycle.
REQ-028 FWD_EN=0: add $5 followed by an $5 reader -> 3 stall cycles, forward always 00.
REQ-029 Writes to $0 followed by a $0 reader -> forward 00 and no stall; rst asserted mid-hold -> ex_hold=0 on the next cycle.
